// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM,
// one-entry valid/ready holding register with error pulses.
module uart_rx #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_i,
  input  logic       uart_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_busy_o,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o
);

  localparam int ClocksPerBit = ClockFrequency / BaudRate;
  localparam int HalfBit      = ClocksPerBit / 2;
  localparam int CntW         = $clog2(ClocksPerBit);

  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(ClocksPerBit - 1);

  if (ClocksPerBit < 4) begin : g_cpb_check
    $error("uart_rx: ClocksPerBit must be >= 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            sync1;
  logic            rxs;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      sync1          <= 1'b1;
      rxs            <= 1'b1;
      rx_data_o      <= '0;
      rx_valid_o     <= 1'b0;
      rx_busy_o      <= 1'b0;
      rx_frame_err_o <= 1'b0;
      rx_overrun_o   <= 1'b0;
    end else begin
      sync1          <= uart_rx_i;
      rxs            <= sync1;
      rx_frame_err_o <= 1'b0;
      rx_overrun_o   <= 1'b0;
      cnt            <= cnt + 1'b1;
      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state     <= S_START;
            rx_busy_o <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == HalfLast) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (rxs) begin
              state     <= S_IDLE;
              rx_busy_o <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (cnt == BitLast) begin
            cnt     <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (cnt == BitLast) begin
            cnt <= '0;
            if (rxs) begin
              state     <= S_IDLE;
              rx_busy_o <= 1'b0;
              // a same-cycle accept frees the slot for the new byte
              if (!rx_valid_o || rx_ready_i) begin
                rx_data_o  <= shift;
                rx_valid_o <= 1'b1;
              end else begin
                rx_overrun_o <= 1'b1;
              end
            end else begin
              state          <= S_WAIT_HIGH;
              rx_frame_err_o <= 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          cnt <= '0;
          if (rxs) begin
            state     <= S_IDLE;
            rx_busy_o <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          rx_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames, corner sequences,
// and random frames against a frame-level holding-register model.
module tb_uart_rx;

  localparam int C    = 16;
  localparam int H    = C / 2;
  localparam int SOFF = 3 + H + 9 * C;

  logic       clk_sys_i;
  logic       rst_sys_i;
  logic       uart_rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       rx_busy_o;
  logic       rx_frame_err_o;
  logic       rx_overrun_o;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic prev_f = 1'b0;
  logic prev_o = 1'b0;

  uart_rx #(
    .ClockFrequency(16),
    .BaudRate      (1)
  ) dut (
    .clk_sys_i     (clk_sys_i),
    .rst_sys_i     (rst_sys_i),
    .uart_rx_i     (uart_rx_i),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .rx_busy_o     (rx_busy_o),
    .rx_frame_err_o(rx_frame_err_o),
    .rx_overrun_o  (rx_overrun_o)
  );

  initial clk_sys_i = 1'b0;
  always #5 clk_sys_i = ~clk_sys_i;

  always @(negedge clk_sys_i) begin
    if (rx_frame_err_o || rx_overrun_o) begin
      n_checks++;
      if ((rx_frame_err_o && rx_overrun_o) ||
          (rx_frame_err_o && prev_f) ||
          (rx_overrun_o && prev_o)) begin
        n_fail++;
        $display("FAIL pulse_shape: ferr=%b ovr=%b prev_ferr=%b prev_ovr=%b, required single isolated pulse",
                 rx_frame_err_o, rx_overrun_o, prev_f, prev_o);
      end
    end
    if (rx_frame_err_o) ferr_cnt++;
    if (rx_overrun_o) ovr_cnt++;
    prev_f = rx_frame_err_o;
    prev_o = rx_overrun_o;
  end

  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    uart_rx_i = 1'b1;
    repeat (n) tick();
  endtask

  task automatic accept(input logic exp_after);
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    chk("accept_valid", rx_valid_o, exp_after);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic rdy_s, input int hold,
                            input logic pre_v, input logic exp_v,
                            input logic [7:0] exp_d, input logic exp_f,
                            input logic exp_o);
    logic [9:0] bits;
    int f0;
    int o0;
    bits = {stop, d, 1'b0};
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    for (int i = 0; i < 10 * C; i++) begin
      if (i == SOFF - 1) chk("valid_pre", rx_valid_o, pre_v);
      if (i == SOFF) begin
        chk("valid", rx_valid_o, exp_v);
        chk("data", rx_data_o, exp_d);
        chk("ferr_at_s", rx_frame_err_o, exp_f);
        chk("ovr_at_s", rx_overrun_o, exp_o);
        chk("busy_at_s", rx_busy_o, !stop);
      end
      if (i == SOFF + 1) begin
        chk("ferr_width", rx_frame_err_o, 1'b0);
        chk("ovr_width", rx_overrun_o, 1'b0);
      end
      uart_rx_i  = bits[i/C];
      rx_ready_i = rdy_s && (i == SOFF - 1);
      tick();
    end
    rx_ready_i = 1'b0;
    if (!stop) begin
      repeat (hold) tick();
      chk("busy_wait_high", rx_busy_o, 1'b1);
      chk("valid_wait_high", rx_valid_o, exp_v);
      uart_rx_i = 1'b1;
      repeat (4) tick();
      chk("busy_released", rx_busy_o, 1'b0);
    end
    chk("ferr_count", ferr_cnt - f0, 32'(exp_f));
    chk("ovr_count", ovr_cnt - o0, 32'(exp_o));
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rdy_s;
    int         gap;
    int         hold;
    logic       accept;
    logic       exp_v;
    logic [7:0] exp_d;
    logic       exp_f;
    logic       exp_o;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic       mv;
    logic [7:0] md;
    logic [7:0] rd;
    logic       rs;
    logic       rr;
    logic       ev;
    logic       eo;
    logic       acc;
    logic [9:0] bits;
    int         bc;
    int         f0;
    int         o0;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 20, 0,   1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 10, 100, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{8'h81, 1'b1, 1'b0, 10, 0,   1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
    tbl[3] = '{8'h11, 1'b1, 1'b0, 10, 0,   1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    tbl[4] = '{8'h22, 1'b1, 1'b0, 0,  0,   1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
    tbl[5] = '{8'h22, 1'b1, 1'b1, 0,  0,   1'b0, 1'b1, 8'h22, 1'b0, 1'b0};

    rst_sys_i  = 1'b1;
    uart_rx_i  = 1'b1;
    rx_ready_i = 1'b0;
    repeat (3) tick();
    chk("rst_valid", rx_valid_o, 1'b0);
    chk("rst_data", rx_data_o, 8'h00);
    chk("rst_busy", rx_busy_o, 1'b0);
    chk("rst_ferr", rx_frame_err_o, 1'b0);
    chk("rst_ovr", rx_overrun_o, 1'b0);
    rst_sys_i = 1'b0;

    mv = 1'b0;
    for (int k = 0; k < 6; k++) begin
      idle(tbl[k].gap);
      send_frame(tbl[k].data, tbl[k].stop, tbl[k].rdy_s, tbl[k].hold,
                 mv, tbl[k].exp_v, tbl[k].exp_d, tbl[k].exp_f,
                 tbl[k].exp_o);
      mv = tbl[k].exp_v;
      if (tbl[k].accept) begin
        accept(1'b0);
        mv = 1'b0;
      end
    end

    // short low glitch must be rejected at the start-bit midpoint
    idle(10);
    f0 = ferr_cnt;
    bc = 0;
    for (int i = 0; i < 24; i++) begin
      uart_rx_i = (i < 4) ? 1'b0 : 1'b1;
      tick();
      if (rx_busy_o) bc++;
    end
    chk("glitch_busy_len", 32'((bc > 0) && (bc <= 8)), 32'd1);
    chk("glitch_busy_end", rx_busy_o, 1'b0);
    chk("glitch_valid", rx_valid_o, 1'b1);
    chk("glitch_data", rx_data_o, 8'h22);
    chk("glitch_ferr", ferr_cnt - f0, 32'd0);

    // reset during data bit 4 of 0xF0
    idle(5);
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    bits = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 10 * C; i++) begin
      uart_rx_i = bits[i/C];
      rst_sys_i = (i == 5 * C + H);
      tick();
      if (i == 5 * C + H) begin
        chk("midrst_valid", rx_valid_o, 1'b0);
        chk("midrst_data", rx_data_o, 8'h00);
        chk("midrst_busy", rx_busy_o, 1'b0);
        chk("midrst_ferr", rx_frame_err_o, 1'b0);
        chk("midrst_ovr", rx_overrun_o, 1'b0);
      end
    end
    rst_sys_i = 1'b0;
    idle(20);
    chk("postrst_valid", rx_valid_o, 1'b0);
    chk("postrst_busy", rx_busy_o, 1'b0);
    chk("postrst_pulses", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);

    // random frames against a frame-level holding-register model
    mv = 1'b1;
    md = 8'h5A;
    for (int k = 0; k < 14; k++) begin
      rd  = 8'($urandom_range(0, 255));
      rs  = ($urandom_range(0, 4) != 0);
      rr  = 1'($urandom_range(0, 1));
      acc = 1'($urandom_range(0, 1));
      eo  = 1'b0;
      if (!rs) begin
        ev = mv && !rr;
      end else if (!mv || rr) begin
        ev = 1'b1;
        md = rd;
      end else begin
        ev = 1'b1;
        eo = 1'b1;
      end
      idle($urandom_range(0, 20));
      send_frame(rd, rs, rr, $urandom_range(0, 20), mv, ev, md,
                 !rs, eo);
      mv = ev;
      if (acc) begin
        accept(1'b0);
        mv = 1'b0;
      end
    end

    idle(10);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
